case_6_mul_share_rr_ctrl: RTL

//  Shares one signed 8s x 4s -> 8-bit multiplier between NUM_REQ requesters.

---
 rtl/case_6_mul_share_rr_ctrl_if.sv | 28 ++
 rtl/case_6_mul_share_rr_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/case_6_mul_share_rr_ctrl_if.sv
// case_6_mul_share_rr_ctrl_if: request/response bundle for the shared multiplier.
//   req_valid/req_ready/req_a/req_b : per-requester request channels (packed slices)
//   rsp_valid/rsp_ready/rsp_data/rsp_id : single tagged response channel
//   master = requester/consumer side, slave = multiplier controller side
interface case_6_mul_share_rr_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 8,
  parameter int B_W     = 4,
  parameter int P_W     = 8
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [P_W-1:0]         rsp_data;
  logic [ID_W-1:0]        rsp_id;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/case_6_mul_share_rr_ctrl.sv
// case_6_mul_share_rr_ctrl: round-robin sharing of one signed A_W x B_W multiplier
// across NUM_REQ requesters through a 2-stage (operand reg -> result reg) pipeline.
//   ap_clk, ap_rst_n : clock, async active-low reset
//   bus (slave)      : per-requester request channels, tagged response channel
//   busy             : any pipeline stage holds data
//   done_cnt         : saturating count of completed responses
module case_6_mul_share_rr_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 8,
  parameter int B_W     = 4,
  parameter int P_W     = 8,
  parameter int CNT_W   = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  case_6_mul_share_rr_ctrl_if.slave bus,
  output logic                      busy,
  output logic [CNT_W-1:0]          done_cnt
);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic signed [A_W-1:0] s1_a_q, s1_a_d;
  logic signed [B_W-1:0] s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d, rr_ptr_q, rr_ptr_d;
  logic [P_W-1:0] s2_data_q, s2_data_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [ID_W-1:0] gnt_idx, scan_idx;
  logic [NUM_REQ-1:0] gnt;
  logic gnt_any, s2_load, s1_adv, accept, req_hs, rsp_hs;
  logic signed [A_W+B_W-1:0] prod;
  always_comb begin
    s2_load  = !s2_valid_q || bus.rsp_ready;
    s1_adv   = s1_valid_q && s2_load;
    accept   = !s1_valid_q || s2_load;
    gnt_any  = 1'b0;
    gnt_idx  = rr_ptr_q;
    scan_idx = rr_ptr_q;
    // first valid requester after the last granted one wins
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_any && bus.req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    // gated by reset so req_ready reads 0 while the block is held in reset
    gnt        = (ap_rst_n && accept && gnt_any) ? NUM_REQ'(1) << gnt_idx : '0;
    req_hs     = |gnt;
    rsp_hs     = s2_valid_q && bus.rsp_ready;
    prod       = (A_W+B_W)'(s1_a_q) * (A_W+B_W)'(s1_b_q);
    s1_valid_d = req_hs || (s1_valid_q && !s1_adv);
    s1_a_d     = req_hs ? bus.req_a[gnt_idx*A_W +: A_W] : s1_a_q;
    s1_b_d     = req_hs ? bus.req_b[gnt_idx*B_W +: B_W] : s1_b_q;
    s1_id_d    = req_hs ? gnt_idx : s1_id_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s2_data_d  = s2_load ? prod[P_W-1:0] : s2_data_q;
    s2_id_d    = s2_load ? s1_id_q : s2_id_q;
    rr_ptr_d   = req_hs ? gnt_idx : rr_ptr_q;
    done_cnt_d = (rsp_hs && done_cnt_q != '1) ? done_cnt_q + CNT_W'(1) : done_cnt_q;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= ID_W'(NUM_REQ-1);
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
      done_cnt_q <= done_cnt_d;
    end
  end
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_data  = s2_data_q;
  assign bus.rsp_id    = s2_id_q;
  assign busy          = s1_valid_q || s2_valid_q;
  assign done_cnt      = done_cnt_q;
endmodule
